// File: rtl/sdram_port_arbiter.sv
// Round-robin arbiter sharing one SDRAM controller port between two cache-style
// requesters; the grant is held until the read burst or the write ack completes.
module sdram_port_arbiter #(
  parameter int BURST = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_rw,
  input  logic [31:0] p0_addr,
  input  logic [15:0] p0_wdata,
  input  logic [1:0]  p0_bytesel,
  output logic        p0_fill,
  output logic        p0_ack,
  input  logic        p1_req,
  input  logic        p1_rw,
  input  logic [31:0] p1_addr,
  input  logic [15:0] p1_wdata,
  input  logic [1:0]  p1_bytesel,
  output logic        p1_fill,
  output logic        p1_ack,
  output logic [15:0] rdata,
  output logic [1:0]  grant,
  output logic        sdram_req,
  output logic        sdram_rw,
  output logic [31:0] sdram_addr,
  output logic [15:0] sdram_wdata,
  output logic [1:0]  sdram_bytesel,
  input  logic        sdram_fill,
  input  logic        sdram_ack,
  input  logic [15:0] sdram_rdata
);

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_BURST, WR_WAIT, GAP} state_t;

  state_t      state;
  logic        last;
  logic [3:0]  word_cnt;
  logic        any_req;
  logic        pick;
  logic        sel_rw;
  logic [31:0] sel_addr;
  logic [15:0] sel_wdata;
  logic [1:0]  sel_bytesel;

  // On a tie the port that did not win last time gets the grant.
  always_comb begin
    any_req = p0_req | p1_req;
    if (p0_req && p1_req) pick = ~last;
    else                  pick = p1_req & ~p0_req;
    sel_rw      = pick ? p1_rw      : p0_rw;
    sel_addr    = pick ? p1_addr    : p0_addr;
    sel_wdata   = pick ? p1_wdata   : p0_wdata;
    sel_bytesel = pick ? p1_bytesel : p0_bytesel;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      last          <= 1'b1;
      grant         <= 2'b00;
      sdram_req     <= 1'b0;
      sdram_rw      <= 1'b0;
      sdram_addr    <= '0;
      sdram_wdata   <= '0;
      sdram_bytesel <= '0;
      word_cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant         <= pick ? 2'b10 : 2'b01;
            sdram_req     <= 1'b1;
            last          <= pick;
            sdram_rw      <= sel_rw;
            sdram_addr    <= sel_addr;
            sdram_wdata   <= sel_wdata;
            sdram_bytesel <= sel_bytesel;
            state         <= sel_rw ? RD_WAIT : WR_WAIT;
          end
        end
        RD_WAIT: begin
          if (sdram_fill) begin
            sdram_req <= 1'b0;
            word_cnt  <= 4'(BURST - 1);
            state     <= RD_BURST;
          end
        end
        RD_BURST: begin
          word_cnt <= word_cnt - 4'd1;
          if (word_cnt == 4'd1) begin
            grant <= 2'b00;
            state <= GAP;
          end
        end
        WR_WAIT: begin
          if (sdram_ack) begin
            sdram_req <= 1'b0;
            grant     <= 2'b00;
            state     <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes reach only the owner, and only in the state that expects them.
  always_comb begin
    rdata   = sdram_rdata;
    p0_fill = sdram_fill & grant[0] & (state == RD_WAIT);
    p1_fill = sdram_fill & grant[1] & (state == RD_WAIT);
    p0_ack  = sdram_ack  & grant[0] & (state == WR_WAIT);
    p1_ack  = sdram_ack  & grant[1] & (state == WR_WAIT);
  end

endmodule
